sudoku_edit_ctrl: RTL

- Owns the 9x9 Sudoku board register and drives the board vector consumed by the board renderer.
- Translates debounced button pulses into cursor moves and cell edits.
- Commits edits only on a frame refresh tick, so no frame is drawn with a half-updated board.
- After each commit, runs a sequential peer scan (row/column/box) and flags a conflict.

---
 rtl/sudoku_pkg.sv | 11 +
 rtl/sudoku_edit_ctrl_if.sv | 16 +
 rtl/sudoku_peer_gen.sv | 20 ++
 rtl/sudoku_edit_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// sudoku_pkg: board geometry constants, cell indexing and edit FSM states shared by the editor and peer generator.
package sudoku_pkg;
  localparam int N = 9;
  localparam int CELL_W = 4;
  localparam int BOARD_W = 324;
  localparam int BOX = 3;
  typedef enum logic [1:0] {IDLE, WAIT_TICK, CHECK, DONE} state_t;
  function automatic logic [8:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return 9'(r) * 9'd36 + 9'(c) * 9'd4;
  endfunction
endpackage

// File: rtl/sudoku_edit_ctrl_if.sv
// sudoku_edit_ctrl_if: button/tick/puzzle inputs and board/cursor/status outputs of the Sudoku editor.
interface sudoku_edit_ctrl_if;
  import sudoku_pkg::*;
  logic refr_tick, btn_up, btn_down, btn_left, btn_right, btn_inc, btn_clear, load;
  logic [0:BOARD_W-1] puzzle, sudoku;
  logic [3:0] cursor_row, cursor_col;
  logic fixed_at_cursor, busy, conflict, filled;
  modport master (
    output refr_tick, btn_up, btn_down, btn_left, btn_right, btn_inc, btn_clear, load, puzzle,
    input sudoku, cursor_row, cursor_col, fixed_at_cursor, busy, conflict, filled
  );
  modport slave (
    input refr_tick, btn_up, btn_down, btn_left, btn_right, btn_inc, btn_clear, load, puzzle,
    output sudoku, cursor_row, cursor_col, fixed_at_cursor, busy, conflict, filled
  );
endinterface

// File: rtl/sudoku_peer_gen.sv
// sudoku_peer_gen: maps scan slot k (0-26) for cell (r,c) to its row/column/box peer and flags the self slot.
module sudoku_peer_gen
  import sudoku_pkg::*;
(
  input  logic [4:0] k,
  input  logic [3:0] r,
  input  logic [3:0] c,
  output logic [3:0] pr,
  output logic [3:0] pc,
  output logic       is_self
);
  logic [4:0] j;
  logic [3:0] br, bc;
  assign j = k - 5'd18;
  assign br = r / 4'(BOX) * 4'(BOX);
  assign bc = c / 4'(BOX) * 4'(BOX);
  assign pr = k < 5'd9 ? r : k < 5'd18 ? 4'(k - 5'd9) : br + 4'(j / 5'(BOX));
  assign pc = k < 5'd9 ? k[3:0] : k < 5'd18 ? c : bc + 4'(j % 5'(BOX));
  assign is_self = pr == r && pc == c;
endmodule

// File: rtl/sudoku_edit_ctrl.sv
// sudoku_edit_ctrl: Sudoku board owner; edits commit on refr_tick, then a 27-slot peer scan sets conflict.
// Define SUDOKU_CURSOR_WRAP_EN to make the cursor wrap at board edges instead of saturating.
module sudoku_edit_ctrl #(
  parameter int SCAN_LEN = 27,
  parameter int MAX_VAL = 9
) (
  input logic clk,
  input logic reset,
  sudoku_edit_ctrl_if.slave bus
);
  import sudoku_pkg::*;
`ifdef SUDOKU_CURSOR_WRAP_EN
  localparam logic [3:0] BELOW0 = 4'd8;
  localparam logic [3:0] ABOVE8 = 4'd0;
`else
  localparam logic [3:0] BELOW0 = 4'd0;
  localparam logic [3:0] ABOVE8 = 4'd8;
`endif
  logic [0:BOARD_W-1] board;
  logic [N*N-1:0] fixed;
  logic [3:0] cur_r, cur_c, tr, tc, tv, pr, pc, cur_d, peer_d;
  logic [4:0] k;
  logic hit, conflict, is_self, edit_ok, busy, filled;
  state_t state, nxt;

  function automatic logic [3:0] step(input logic [3:0] v, input logic dn, input logic up);
    return (dn & ~up) ? (v == 4'd0 ? BELOW0 : v - 4'd1) :
           (up & ~dn) ? (v == 4'd8 ? ABOVE8 : v + 4'd1) : v;
  endfunction

  function automatic logic [6:0] fidx(input logic [3:0] r, input logic [3:0] c);
    return 7'(r) * 7'd9 + 7'(c);
  endfunction

  assign cur_d = board[cell_idx(cur_r, cur_c) +: CELL_W];
  assign peer_d = board[cell_idx(pr, pc) +: CELL_W];
  assign edit_ok = state == IDLE && !bus.load && (bus.btn_inc | bus.btn_clear) && !fixed[fidx(cur_r, cur_c)];

  sudoku_peer_gen u_peer (.k(k), .r(tr), .c(tc), .pr(pr), .pc(pc), .is_self(is_self));

  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;

  always_comb
    nxt = bus.load ? IDLE :
          state == IDLE ? (edit_ok ? WAIT_TICK : IDLE) :
          state == WAIT_TICK ? (bus.refr_tick ? (tv == 4'd0 ? IDLE : CHECK) : WAIT_TICK) :
          state == CHECK ? (k == 5'(SCAN_LEN - 1) ? DONE : CHECK) : IDLE;

  always_comb begin
    busy = state != IDLE;
    filled = 1'b1;
    for (int i = 0; i < N * N; i++) filled &= board[i*CELL_W +: CELL_W] != 4'd0;
  end

  // Load outranks edits; moves apply in every state alongside whatever else happens.
  always_ff @(posedge clk)
    if (reset) begin
      board <= '0;
      fixed <= '0;
      cur_r <= '0;
      cur_c <= '0;
      tr <= '0;
      tc <= '0;
      tv <= '0;
      k <= '0;
      hit <= 1'b0;
      conflict <= 1'b0;
    end else begin
      cur_r <= step(cur_r, bus.btn_up, bus.btn_down);
      cur_c <= step(cur_c, bus.btn_left, bus.btn_right);
      if (bus.load) begin
        board <= bus.puzzle;
        for (int i = 0; i < N * N; i++) fixed[i] <= bus.puzzle[i*CELL_W +: CELL_W] != 4'd0;
        conflict <= 1'b0;
      end else if (edit_ok) begin
        tr <= cur_r;
        tc <= cur_c;
        tv <= bus.btn_clear ? 4'd0 : cur_d >= 4'(MAX_VAL) ? 4'd0 : cur_d + 4'd1;
      end else if (state == WAIT_TICK && bus.refr_tick) begin
        board[cell_idx(tr, tc) +: CELL_W] <= tv;
        k <= '0;
        hit <= 1'b0;
        if (tv == 4'd0) conflict <= 1'b0;
      end else if (state == CHECK) begin
        k <= k + 5'd1;
        if (!is_self && peer_d == tv) hit <= 1'b1;
      end else if (state == DONE) conflict <= hit;
    end

  assign bus.sudoku = board;
  assign bus.cursor_row = cur_r;
  assign bus.cursor_col = cur_c;
  assign bus.fixed_at_cursor = fixed[fidx(cur_r, cur_c)];
  assign bus.busy = busy;
  assign bus.conflict = conflict;
  assign bus.filled = filled;
endmodule
